// File: rtl/stream_deserializer_if.sv
// Valid/ready bundle between a narrow upstream lane and a wide downstream word.
// Ports: up_bus/up_last/up_val/up_rdy (narrow side), dn_bus/dn_cnt/dn_last/dn_val/dn_rdy (wide side).
interface stream_deserializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
);
    localparam int CNT_WIDTH = $clog2(RATIO) + 1;

    logic [DATA_WIDTH-1:0]       up_bus;
    logic                        up_last;
    logic                        up_val;
    logic                        up_rdy;
    logic [DATA_WIDTH*RATIO-1:0] dn_bus;
    logic [CNT_WIDTH-1:0]        dn_cnt;
    logic                        dn_last;
    logic                        dn_val;
    logic                        dn_rdy;

    modport master (
        output up_bus, up_last, up_val, dn_rdy,
        input  up_rdy, dn_bus, dn_cnt, dn_last, dn_val
    );

    modport slave (
        input  up_bus, up_last, up_val, dn_rdy,
        output up_rdy, dn_bus, dn_cnt, dn_last, dn_val
    );
endinterface

// File: rtl/stream_deserializer.sv
// Narrow-to-wide width converter: packs RATIO upstream lanes into one registered word.
// Ports: clk, rst (sync, active-high), bus (slave modport of stream_deserializer_if).
module stream_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input logic                  clk,
    input logic                  rst,
    stream_deserializer_if.slave bus
);
    localparam int IDX_W     = $clog2(RATIO);
    localparam int CNT_WIDTH = IDX_W + 1;
    localparam int W         = DATA_WIDTH * RATIO;
    localparam int AW        = DATA_WIDTH * (RATIO - 1);

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [W-1:0]         dn_bus_q, dn_bus_d;
    logic [CNT_WIDTH-1:0] dn_cnt_q, dn_cnt_d;
    logic                 dn_last_q, dn_last_d;
    logic                 dn_val_q, dn_val_d;

    logic                 dn_active;
    logic                 up_fire;
    logic                 complete;
    logic [W-1:0]         acc_ext;
    logic [W-1:0]         word;

    // Ready depends only on the output register, never on up_val/up_last.
    assign dn_active = ~dn_val_q | bus.dn_rdy;
    assign up_fire   = bus.up_val & dn_active;
    assign complete  = up_fire &
                       (bus.up_last | (idx_q == IDX_W'(RATIO - 1)));

    // Zero-extended accumulator so every lane can be indexed uniformly.
    assign acc_ext = {{DATA_WIDTH{1'b0}}, acc_q};

    // Lanes below idx from acc, current beat at idx, zeros above.
    always_comb begin
        word = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (i < int'(idx_q)) begin
                word[i*DATA_WIDTH +: DATA_WIDTH] =
                    acc_ext[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (i == int'(idx_q)) begin
                word[i*DATA_WIDTH +: DATA_WIDTH] = bus.up_bus;
            end
        end
    end

    always_comb begin
        idx_d     = idx_q;
        acc_d     = acc_q;
        dn_bus_d  = dn_bus_q;
        dn_cnt_d  = dn_cnt_q;
        dn_last_d = dn_last_q;
        dn_val_d  = dn_val_q;
        if (complete) begin
            dn_bus_d  = word;
            dn_cnt_d  = CNT_WIDTH'(idx_q) + CNT_WIDTH'(1);
            dn_last_d = bus.up_last;
            dn_val_d  = 1'b1;
            idx_d     = '0;
            acc_d     = '0;
        end else begin
            // Non-completing beat: idx < RATIO-1, so the lane fits in acc.
            if (up_fire) begin
                acc_d = word[AW-1:0];
                idx_d = idx_q + IDX_W'(1);
            end
            if (bus.dn_rdy) begin
                dn_val_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            acc_q     <= '0;
            dn_bus_q  <= '0;
            dn_cnt_q  <= '0;
            dn_last_q <= 1'b0;
            dn_val_q  <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            dn_bus_q  <= dn_bus_d;
            dn_cnt_q  <= dn_cnt_d;
            dn_last_q <= dn_last_d;
            dn_val_q  <= dn_val_d;
        end
    end

    assign bus.up_rdy  = dn_active;
    assign bus.dn_bus  = dn_bus_q;
    assign bus.dn_cnt  = dn_cnt_q;
    assign bus.dn_last = dn_last_q;
    assign bus.dn_val  = dn_val_q;
endmodule

// File: doc/stream_deserializer.md
Name: stream_deserializer

Overview:
- Receive-side width converter for the team's valid/ready streaming fabric.
- Gathers RATIO narrow beats from an upstream valid/ready stream into one wide registered word on a downstream valid/ready stream.
- An upstream last flag closes a partial word early.
- Sits at the wide end of a narrow link (the counterpart of a wide-to-narrow serializer), typically followed by a skid register stage.

Parameters:
DATA_WIDTH, 8, width of one upstream beat (lane)
RATIO, 4, lanes per downstream word; legal range 2..256
CNT_WIDTH, derived localparam = clog2(RATIO)+1, width of dn_cnt

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
up_bus  input  DATA_WIDTH  narrow beat data
up_last  input  1  beat is final beat of a packet; closes the current word
up_val  input  1  upstream beat valid
up_rdy  output  1  upstream may transfer this cycle
dn_bus  output  DATA_WIDTH*RATIO  assembled word, lane 0 in LSBs
dn_cnt  output  CNT_WIDTH  number of valid lanes in dn_bus, 1..RATIO
dn_last  output  1  word contains the packet's final beat
dn_val  output  1  downstream word valid
dn_rdy  input  1  downstream accepts word this cycle

Behaviour:
- Transfer rules:
  - Upstream transfer occurs when up_val & up_rdy.
  - Downstream transfer occurs when dn_val & dn_rdy.
- dn_active = ~dn_val | dn_rdy; up_rdy = dn_active, combinational. There is no path from up_val or up_last to up_rdy.
- State:
  - idx, lane counter 0..RATIO-1.
  - acc, DATA_WIDTH*(RATIO-1) partial-word register holding lanes 0..RATIO-2.
  - Output registers dn_bus, dn_cnt, dn_last, dn_val.
- Accepted beat is non-completing (idx != RATIO-1 and up_last=0):
  - up_bus written to acc lane idx.
  - idx <= idx+1.
  - Output registers unchanged, except dn_val clears if dn_rdy.
- Accepted beat is completing (idx == RATIO-1 or up_last=1):
  - dn_bus <= acc lanes 0..idx-1, plus up_bus in lane idx, plus zeros in lanes idx+1..RATIO-1.
  - dn_cnt <= idx+1.
  - dn_last <= up_last.
  - dn_val <= 1.
  - idx <= 0.
  - acc cleared to 0.
- Latency: the completing beat accepted at cycle N gives dn_val=1 with that word at cycle N+1.
- No completing beat accepted and dn_rdy=1: dn_val <= 0 next cycle.
- Simultaneous downstream drain and completing upstream beat in the same cycle: the new word replaces the old one with dn_val held at 1. Full throughput is one word every RATIO cycles, with no bubble.
- Stall (dn_val & ~dn_rdy):
  - up_rdy=0.
  - dn_bus, dn_cnt and dn_last held stable; dn_val held at 1.
  - idx and acc unchanged.
- dn_val never falls unless dn_rdy was high the previous cycle.
- A stall blocks every upstream beat, not only completing ones. This is an accepted throughput cost in exchange for the upstream-independent up_rdy.
- up_last on lane 0: one-lane word, dn_cnt=1, dn_last=1.
- up_last on lane RATIO-1: full word, dn_cnt=RATIO, dn_last=1.
- up_val=0 with up_rdy=1: no state change to idx or acc.
- Reset:
  - idx=0, acc=0, dn_val=0, dn_bus=0, dn_cnt=0, dn_last=0.
  - Output up_rdy=1 on the first cycle after reset, since dn_val=0.
  - Reset mid-word discards the partial word; reset while stalled discards the pending output word.
  - Reset has priority over all transfers in the same cycle.
- Upstream protocol the block relies on: up_bus and up_last stable while up_val & ~up_rdy, and up_val does not fall without a transfer.

Test Plan:
- Full words, dn_rdy=1 held, DATA_WIDTH=8, RATIO=4, beats 0x11,0x22,0x33,0x44 on consecutive cycles, up_last=0 → dn_bus=0x44332211, dn_cnt=4, dn_last=0 on the cycle after 0x44. up_rdy stays 1 throughout. Streaming 8 beats yields 2 words 4 cycles apart.
- Partial word: beats 0xAA,0xBB with up_last on 0xBB → dn_bus=0x0000BBAA, dn_cnt=2, dn_last=1. The next beat 0xCC lands in lane 0 (dn_bus=0x000000CC after completion).
- Single-beat packet: 0x5A with up_last=1 at idx=0 → dn_bus=0x0000005A, dn_cnt=1, dn_last=1, one cycle later.
- Backpressure:
  - Hold dn_rdy=0 for 5 cycles with dn_val=1 → up_rdy=0 and dn_bus/dn_cnt/dn_last stable for all 5 cycles.
  - Upstream beat 0x77 presented meanwhile is accepted only on the cycle dn_rdy rises, and lands in the correct lane.
- Back-to-back drain with completing beat in the same cycle: dn_rdy=1 while completing beat 0x44 is accepted → dn_val stays 1 and the new word appears next cycle with no bubble. Random dn_rdy (50%) over 1000 beats → scoreboard shows no lost, duplicated or reordered lanes.
- Reset mid-word: after 0x11,0x22, assert rst for 1 cycle, then send 0x33,0x44,0x55,0x66 → first word is 0x66554433, dn_cnt=4. Reset during a stall leaves dn_val=0 the cycle after rst.
